usb_pkt_rx: RTL

USB packet receiver sitting directly downstream of the ULPI controller. It consumes the received byte stream framed by RxActive and parses the PID. It extracts token fields, strips and checks CRC5/CRC16, and delivers payload bytes plus an end-of-packet status to the USB protocol engine. It is a single clock domain on the ULPI 60 MHz clock.

---
 rtl/usb_pkt_rx.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/usb_pkt_rx.sv
// USB packet receiver: PID check, token field extraction, CRC strip/check, payload delivery.
// Latency: every output is registered, 1 cycle after the input byte; payload byte N leaves 1 cycle after byte N+2.
// Backpressure: none; one byte per cycle accepted indefinitely. Define USB_PKT_RX_CRC_EN to build CRC5/CRC16 checking.
module usb_pkt_rx #(
  parameter int MAX_LEN = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rx_active,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_error,
  output logic [3:0]  o_pid,
  output logic        o_pid_valid,
  output logic [6:0]  o_tok_addr,
  output logic [3:0]  o_tok_endp,
  output logic        o_tok_valid,
  output logic [7:0]  o_data,
  output logic        o_data_valid,
  output logic        o_pkt_end,
  output logic        o_pkt_err,
  output logic [10:0] o_len
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PID,
    S_TOKEN,
    S_DATA,
    S_HSK,
    S_DROP
  } state_t;

  localparam logic [10:0] LEN_MAX = 11'(MAX_LEN);

  state_t      state;
  state_t      cur;
  state_t      pid_state;
  logic        armed;     // cleared by reset so a packet already in flight is skipped
  logic        err;
  logic [1:0]  cnt;       // bytes after the PID (token) or bytes held in the delay buffer (data)
  logic [7:0]  buf0;      // older held byte (also first token byte)
  logic [7:0]  buf1;      // newer held byte
  logic [10:0] len;
  logic        start;
  logic        byte_ok;
  logic        pid_ok;
  logic        crc5_ok;
  logic        crc16_ok;
  logic        end_err;

`ifdef USB_PKT_RX_CRC_EN
  logic [4:0]  crc5;
  logic [15:0] crc16;
  logic [4:0]  crc5_nxt;
  logic [15:0] crc16_nxt;

  // Serial CRC over the incoming byte, LSB first
  always_comb begin
    crc5_nxt  = crc5;
    crc16_nxt = crc16;
    for (int i = 0; i < 8; i++) begin
      if (crc5_nxt[4] ^ i_rx_data[i]) crc5_nxt = {crc5_nxt[3:0], 1'b0} ^ 5'b00101;
      else                            crc5_nxt = {crc5_nxt[3:0], 1'b0};
      if (crc16_nxt[15] ^ i_rx_data[i]) crc16_nxt = {crc16_nxt[14:0], 1'b0} ^ 16'h8005;
      else                              crc16_nxt = {crc16_nxt[14:0], 1'b0};
    end
    crc5_ok  = (crc5 == 5'b01100);
    crc16_ok = (crc16 == 16'h800D);
  end

  // CRC registers restart at all ones for every packet
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      crc5  <= 5'h1F;
      crc16 <= 16'hFFFF;
    end else if (start) begin
      crc5  <= 5'h1F;
      crc16 <= 16'hFFFF;
    end else if (byte_ok && state == S_TOKEN) begin
      crc5  <= crc5_nxt;
    end else if (byte_ok && state == S_DATA) begin
      crc16 <= crc16_nxt;
    end
  end
`else
  assign crc5_ok  = 1'b1;
  assign crc16_ok = 1'b1;
`endif

  // PID decode, packet start qualification and end-of-packet error summary
  always_comb begin
    start   = (state == S_IDLE) && armed && i_rx_active;
    cur     = start ? S_PID : state;
    byte_ok = i_rx_active && !i_rx_error && i_rx_valid;
    pid_ok  = (i_rx_data[3:0] == ~i_rx_data[7:4]);
    pid_state = S_DROP;
    if (pid_ok) begin
      case (i_rx_data[1:0])
        2'b01:   pid_state = S_TOKEN;
        2'b11:   pid_state = S_DATA;
        2'b10:   pid_state = S_HSK;
        default: pid_state = S_DROP;
      endcase
    end
    case (state)
      S_PID:   end_err = 1'b1;
      S_TOKEN: end_err = err || (cnt != 2'd2) || !crc5_ok;
      S_DATA:  end_err = err || (cnt != 2'd2) || !crc16_ok;
      default: end_err = err;
    endcase
  end

  // Packet FSM with registered outputs; a PID byte may arrive in the same cycle RxActive rises
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      armed        <= 1'b0;
      err          <= 1'b0;
      cnt          <= 2'd0;
      buf0         <= 8'd0;
      buf1         <= 8'd0;
      len          <= 11'd0;
      o_pid        <= 4'd0;
      o_pid_valid  <= 1'b0;
      o_tok_addr   <= 7'd0;
      o_tok_endp   <= 4'd0;
      o_tok_valid  <= 1'b0;
      o_data       <= 8'd0;
      o_data_valid <= 1'b0;
      o_pkt_end    <= 1'b0;
      o_pkt_err    <= 1'b0;
      o_len        <= 11'd0;
    end else begin
      o_pid_valid  <= 1'b0;
      o_tok_valid  <= 1'b0;
      o_data_valid <= 1'b0;
      o_pkt_end    <= 1'b0;
      if (state == S_IDLE) begin
        if (!i_rx_active) begin
          armed <= 1'b1;
        end else if (armed) begin
          state <= S_PID;
          err   <= 1'b0;
          cnt   <= 2'd0;
          len   <= 11'd0;
        end
      end
      if (cur != S_IDLE) begin
        if (!i_rx_active) begin
          o_pkt_end   <= 1'b1;
          o_pkt_err   <= end_err;
          o_len       <= len;
          o_tok_valid <= (state == S_TOKEN) && (cnt == 2'd2) && crc5_ok;
          state       <= S_IDLE;
        end else if (i_rx_error) begin
          err   <= 1'b1;
          state <= S_DROP;
        end else if (i_rx_valid) begin
          case (cur)
            S_PID: begin
              state <= pid_state;
              if (pid_ok) begin
                o_pid       <= i_rx_data[3:0];
                o_pid_valid <= 1'b1;
              end
              if (pid_state == S_DROP) err <= 1'b1;
            end
            S_TOKEN: begin
              if (cnt != 2'd3) cnt <= cnt + 2'd1;
              if (cnt == 2'd0) buf0 <= i_rx_data;
              if (cnt == 2'd1) begin
                o_tok_addr <= buf0[6:0];
                o_tok_endp <= {i_rx_data[2:0], buf0[7]};
              end
            end
            S_DATA: begin
              if (cnt == 2'd2) begin
                if (len == LEN_MAX) begin
                  err   <= 1'b1;
                  state <= S_DROP;
                end else begin
                  o_data       <= buf0;
                  o_data_valid <= 1'b1;
                  len          <= len + 11'd1;
                  buf0         <= buf1;
                  buf1         <= i_rx_data;
                end
              end else begin
                cnt <= cnt + 2'd1;
                if (cnt == 2'd0) buf0 <= i_rx_data;
                else             buf1 <= i_rx_data;
              end
            end
            S_HSK:   err <= 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

endmodule
